// File: rtl/adc_y_capture_pkg.sv
// Shared FSM encoding and address-width helper for the adc_y capture buffer.
package adc_y_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_READ  = 3'd4
  } state_e;

  function automatic int addr_bits(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/adc_y_capture_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port (maps to EBR).
module adc_y_capture_ram #(
  parameter int DATA_BITS = 10,
  parameter int DEPTH     = 256,
  parameter int AW        = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [AW-1:0]        raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [DATA_BITS-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/adc_y_capture.sv
// Pre/post-trigger capture of the adc_y sample stream into a DEPTH ring, read out oldest-first.
// Optional: define ADC_Y_CAPTURE_AUTO_TRIG_EN to force a trigger after a TMO_BITS sample timeout.
module adc_y_capture
  import adc_y_capture_pkg::*;
#(
  parameter int DATA_BITS = 10,
  parameter int DEPTH     = 256,
  parameter int PRE_TRIG  = 64,
  parameter int TMO_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 y_valid,
  input  logic [DATA_BITS-1:0] y_data,
  input  logic                 arm,
  input  logic [DATA_BITS-1:0] trig_level,
  input  logic                 trig_rising,
  output logic                 busy,
  output logic                 triggered,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_last,
  output logic                 done
);

  localparam int AW = addr_bits(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_TRIG - 1);
  localparam logic [CW-1:0] POST_LAST = CW'(DEPTH - PRE_TRIG - 2);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);

  state_e               state_q, state_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, trig_addr_q, trig_addr_d;
  logic [CW-1:0]        cnt_q, cnt_d, iss_q, iss_d;
  logic [DATA_BITS-1:0] prev_q, prev_d, odata_q, odata_d, ram_rdata;
  logic                 prev_ok_q, prev_ok_d, trig_q, trig_d, done_q, done_d;
  logic                 dvld_q, dvld_d, dlast_q, dlast_d, ovld_q, ovld_d, olast_q, olast_d;
  logic                 smp, hit_real, hit_auto, trig_fire;
  logic                 hs, fin, out_free, move, rd_en;

  assign smp = y_valid && (state_q == ST_PRE || state_q == ST_ARMED || state_q == ST_POST);

  always_comb begin
    hit_real = 1'b0;
    if (state_q == ST_ARMED && y_valid && prev_ok_q)
      hit_real = trig_rising ? (prev_q < trig_level && y_data >= trig_level)
                             : (prev_q > trig_level && y_data <= trig_level);
  end

`ifdef ADC_Y_CAPTURE_AUTO_TRIG_EN
  logic [TMO_BITS-1:0] tmo_q, tmo_d;

  // Held at zero outside ARMED, so it restarts on every entry.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != ST_ARMED) tmo_d = '0;
    else if (y_valid)        tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end

  assign hit_auto = (state_q == ST_ARMED) && y_valid && (&tmo_q);
`else
  logic unused_tmo_bits;
  assign unused_tmo_bits = (TMO_BITS > 0);
  assign hit_auto = 1'b0;
`endif

  assign trig_fire = hit_real || hit_auto;

  // Readout: RAM output register is a one-deep prefetch in front of the rd_* register.
  assign hs       = ovld_q && rd_ready;
  assign fin      = hs && olast_q;
  assign out_free = !ovld_q || rd_ready;
  assign move     = dvld_q && out_free;
  assign rd_en    = (state_q == ST_READ) && (iss_q != CW'(DEPTH)) && (!dvld_q || move);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (arm) state_d = (PRE_TRIG == 0) ? ST_ARMED : ST_PRE;
      ST_PRE:   if (smp && cnt_q == PRE_LAST) state_d = ST_ARMED;
      ST_ARMED: if (trig_fire) state_d = (DEPTH - PRE_TRIG - 1 == 0) ? ST_READ : ST_POST;
      ST_POST:  if (smp && cnt_q == POST_LAST) state_d = ST_READ;
      ST_READ:  if (fin) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    triggered = trig_q;
    rd_valid  = ovld_q;
    rd_data   = odata_q;
    rd_last   = olast_q;
    done      = done_q;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    prev_ok_d   = prev_ok_q;
    trig_addr_d = trig_addr_q;
    trig_d      = trig_q;
    rd_ptr_d    = rd_ptr_q;
    iss_d       = iss_q;
    dvld_d      = dvld_q;
    dlast_d     = dlast_q;
    ovld_d      = ovld_q;
    odata_d     = odata_q;
    olast_d     = olast_q;
    done_d      = 1'b0;
    if (state_q == ST_IDLE && arm) prev_ok_d = 1'b0;
    if (smp) begin
      wr_ptr_d  = wr_ptr_q + 1'b1;
      prev_d    = y_data;
      prev_ok_d = 1'b1;
      cnt_d     = cnt_q + 1'b1;
    end
    if (state_d != state_q) cnt_d = '0;
    if (trig_fire) begin
      trig_addr_d = wr_ptr_q;
      trig_d      = hit_real;
    end
    if (state_q != ST_READ && state_d == ST_READ) begin
      rd_ptr_d = (trig_fire ? wr_ptr_q : trig_addr_q) - PRE_OFS;
      iss_d    = '0;
      dvld_d   = 1'b0;
      ovld_d   = 1'b0;
      olast_d  = 1'b0;
    end
    if (state_q == ST_READ) begin
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        iss_d    = iss_q + 1'b1;
        dlast_d  = (iss_q == CW'(DEPTH - 1));
      end
      dvld_d = rd_en || (dvld_q && !move);
      if (out_free) begin
        ovld_d  = move;
        olast_d = move && dlast_q;
        if (move) odata_d = ram_rdata;
      end
      if (fin) begin
        ovld_d  = 1'b0;
        olast_d = 1'b0;
        dvld_d  = 1'b0;
        trig_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      prev_ok_q   <= 1'b0;
      trig_addr_q <= '0;
      trig_q      <= 1'b0;
      rd_ptr_q    <= '0;
      iss_q       <= '0;
      dvld_q      <= 1'b0;
      dlast_q     <= 1'b0;
      ovld_q      <= 1'b0;
      odata_q     <= '0;
      olast_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      prev_ok_q   <= prev_ok_d;
      trig_addr_q <= trig_addr_d;
      trig_q      <= trig_d;
      rd_ptr_q    <= rd_ptr_d;
      iss_q       <= iss_d;
      dvld_q      <= dvld_d;
      dlast_q     <= dlast_d;
      ovld_q      <= ovld_d;
      odata_q     <= odata_d;
      olast_q     <= olast_d;
      done_q      <= done_d;
    end
  end

  // prev_q is only trusted once prev_ok_q is set, so it needs no reset.
  always_ff @(posedge clk) prev_q <= prev_d;

  adc_y_capture_ram #(
    .DATA_BITS(DATA_BITS),
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (smp),
    .waddr_i(wr_ptr_q),
    .wdata_i(y_data),
    .re_i   (rd_en),
    .raddr_i(rd_ptr_q),
    .rdata_o(ram_rdata)
  );

endmodule

// File: tb/tb_adc_y_capture.sv
// Bench for adc_y_capture (DEPTH=16, PRE_TRIG=4); auto-trigger case needs ADC_Y_CAPTURE_AUTO_TRIG_EN.
module tb_adc_y_capture;
  localparam int DATA_BITS = 10;
  localparam int DEPTH     = 16;
  localparam int PRE_TRIG  = 4;
  localparam int TMO_BITS  = 4;
`ifdef ADC_Y_CAPTURE_AUTO_TRIG_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic y_valid = 1'b0, arm = 1'b0, trig_rising = 1'b1, rd_ready = 1'b0;
  logic [DATA_BITS-1:0] y_data = '0, trig_level = '0, rd_data;
  logic busy, triggered, rd_valid, rd_last, done;

  always #5 clk = ~clk;

  adc_y_capture #(
    .DATA_BITS(DATA_BITS), .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG), .TMO_BITS(TMO_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .y_valid(y_valid), .y_data(y_data), .arm(arm),
    .trig_level(trig_level), .trig_rising(trig_rising), .busy(busy), .triggered(triggered),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last), .done(done)
  );

  int checks = 0, failures = 0;

  // Behavioural model: the whole accepted sample history, trigger index, record.
  int m_mode = 0;             // 0 idle, 1 capturing, 2 reading out
  int s[$];
  int m_t = -1;
  bit m_trig = 0, m_done = 0;
  int rec[DEPTH];
  int m_idx = 0;
  int got[$];
  int lvl = 0;
  bit rise = 1, held = 1;
  bit p_stall = 0, p_hs = 0, p_hs_last = 0;
  logic [DATA_BITS-1:0] p_data = '0;
  logic p_last = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_t = -1; m_trig = 0; m_done = 0; m_idx = 0;
    p_stall = 0; p_hs = 0; p_hs_last = 0;
    s.delete();
  endtask

  task automatic check_outputs();
    chk("busy", busy, m_mode != 0);
    chk("triggered", triggered, m_trig);
    chk("done", done, m_done);
    if (m_mode != 2) chk("rd_valid_outside_read", rd_valid, 0);
    if (m_mode == 0) chk("rd_last_idle", rd_last, 0);
    if (p_stall) begin
      chk("stall_valid", rd_valid, 1);
      chk("stall_data", rd_data, p_data);
      chk("stall_last", rd_last, p_last);
    end
    if (held && p_hs && !p_hs_last) chk("sustained_valid", rd_valid, 1);
  endtask

  // Advance the model across the coming clock edge for the inputs just driven.
  task automatic model_step(input bit a, input bit v, input int d, input bit rdy);
    int k;
    bit real_tr, forced;
    m_done = 0;
    p_stall = rd_valid && !rdy; p_data = rd_data; p_last = rd_last;
    p_hs = rd_valid && rdy; p_hs_last = rd_last;
    case (m_mode)
      0: if (a) begin m_mode = 1; m_t = -1; s.delete(); end
      1: if (v) begin
        s.push_back(d);
        k = s.size() - 1;
        if (m_t < 0 && k >= PRE_TRIG) begin
          real_tr = (k >= 1) && (rise ? (s[k-1] < lvl && d >= lvl) : (s[k-1] > lvl && d <= lvl));
          forced  = AUTO && (k - PRE_TRIG == (1 << TMO_BITS) - 1);
          if (real_tr || forced) begin m_t = k; m_trig = real_tr; end
        end
        if (m_t >= 0 && k == m_t + DEPTH - PRE_TRIG - 1) begin
          for (int j = 0; j < DEPTH; j++) rec[j] = s[m_t - PRE_TRIG + j];
          m_mode = 2; m_idx = 0;
        end
      end
      default: if (rd_valid && rdy) begin
        chk("rd_data", rd_data, rec[m_idx]);
        chk("rd_last", rd_last, m_idx == DEPTH - 1);
        got.push_back(int'(rd_data));
        m_idx++;
        if (m_idx == DEPTH) begin m_mode = 0; m_done = 1; m_trig = 0; end
      end
    endcase
  endtask

  function automatic int gen(input int kind, input int n);
    case (kind)
      0: return n;
      1: return 100 - n;
      2: return n % 12;
      3: return 3;
      default: return int'($urandom_range(0, 1023));
    endcase
  endfunction

  task automatic run_scn(input int kind, input int level, input bit rising, input bit rnd_rdy,
                         input bit arm_noise, input bit rnd_valid, input int abort_at, input int budget);
    int cyc = 0, n = 0, d;
    bit fin = 0, a, v, r;
    trig_level = level[DATA_BITS-1:0]; trig_rising = rising; lvl = level; rise = rising;
    held = !rnd_rdy; got.delete();
    while (!fin && cyc < budget) begin
      @(negedge clk);
      check_outputs();
      if (abort_at > 0 && m_mode == 2 && m_idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_triggered", triggered, 0);
        chk("reset_rd_last", rd_last, 0);
        model_reset();
        arm = 0; y_valid = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      a = (cyc == 0) || (arm_noise && m_mode != 0 && $urandom_range(0, 3) == 0);
      v = rnd_valid ? ($urandom_range(0, 2) != 0) : (cyc % 2 == 1);
      d = gen(kind, n);
      if (v) n++;
      r = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      arm = a; y_valid = v; y_data = d[DATA_BITS-1:0]; rd_ready = r;
      model_step(a, v, d, r);
      if (cyc > 0 && m_mode == 0) fin = 1;
      cyc++;
    end
    chk("scenario_completed", fin, 1);
    @(negedge clk);
    check_outputs();
    arm = 0; y_valid = 0; rd_ready = 1;
    model_step(0, 0, 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_data", rd_data, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Rising ramp through 10.
    run_scn(0, 10, 1, 0, 0, 0, 0, 400);
    chk("s1_count", got.size(), 16);
    chk("s1_first", got[0], 6);
    chk("s1_last", got[15], 21);

    // Falling ramp through 50.
    run_scn(1, 50, 0, 0, 0, 0, 0, 400);
    chk("s2_first", got[0], 54);
    chk("s2_trig_word", got[4], 50);
    chk("s2_last", got[15], 39);

    // Random backpressure on the same record.
    run_scn(0, 10, 1, 1, 0, 0, 0, 600);
    chk("s3_count", got.size(), 16);
    chk("s3_first", got[0], 6);
    chk("s3_last", got[15], 21);

    // Sawtooth: crossing during PRE and already-crossed level at ARMED entry; stray arms.
    run_scn(2, 2, 1, 1, 1, 0, 0, 800);
    chk("s4_first", got[0], 10);
    chk("s4_trig_word", got[4], 2);
    chk("s4_last", got[15], 1);

    // Reset part-way through readout, then a clean re-capture.
    run_scn(0, 10, 1, 0, 0, 0, 7, 400);
    run_scn(0, 10, 1, 0, 0, 0, 0, 400);
    chk("s5_count", got.size(), 16);
    chk("s5_first", got[0], 6);
    chk("s5_last", got[15], 21);

`ifdef ADC_Y_CAPTURE_AUTO_TRIG_EN
    run_scn(3, 10, 1, 0, 0, 0, 0, 400);
    chk("s6_count", got.size(), 16);
    chk("s6_first", got[0], 3);
    chk("s6_last", got[15], 3);
    chk("s6_forced_index", m_t, PRE_TRIG + 15);
`else
    @(negedge clk);
    check_outputs();
    trig_level = 10; trig_rising = 1; lvl = 10; rise = 1; held = 1;
    arm = 1; y_valid = 0; y_data = 3; rd_ready = 1;
    model_step(1, 0, 3, 1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check_outputs();
      arm = 0; y_valid = i[0]; y_data = 3;
      model_step(0, i[0], 3, 1);
    end
    @(negedge clk);
    check_outputs();
    chk("flat_still_busy", busy, 1);
    chk("flat_no_trigger", m_t, 32'hFFFF_FFFF);
    rst_n = 1'b0;
    #1;
    chk("flat_reset_busy", busy, 0);
    model_reset();
    y_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Random data, levels, strobes and backpressure, with arm coinciding with a strobe allowed.
    for (int i = 0; i < 4; i++)
      run_scn(4, int'($urandom_range(100, 900)), 1'($urandom_range(0, 1)), 1, 1, 1, 0, 4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
